// File: rtl/motor_position_sensor_emulator_module.sv
// Motor position sensor emulator: quadrature A/B/Z encoder and UVW hall outputs
// driven by an internal mechanical count stepped at a programmable rate.
module motor_position_sensor_emulator_module #(
    parameter int ENCODER_LINES = 1000,
    parameter int POLE_PAIRS    = 4
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        emulator_enable_in,
    input  logic        rotate_direction_in,
    input  logic [15:0] step_period_in,
    input  logic        position_load_in,
    input  logic [15:0] position_in,
    output logic        encoder_a_out,
    output logic        encoder_b_out,
    output logic        encoder_z_out,
    output logic        hall_u_out,
    output logic        hall_v_out,
    output logic        hall_w_out,
    output logic [15:0] mech_count_out,
    output logic        step_valid_out
);

    localparam int CPR_INT = 4 * ENCODER_LINES;
    localparam int CPE_INT = CPR_INT / POLE_PAIRS;

    localparam logic [15:0] LP_CPR = 16'(CPR_INT);
    localparam logic [15:0] LP_CPE = 16'(CPE_INT);

    // Sector k begins where 6*elec >= k*CPE, avoiding a runtime divide.
    localparam logic [31:0] LP_T1 = 32'(1 * CPE_INT);
    localparam logic [31:0] LP_T2 = 32'(2 * CPE_INT);
    localparam logic [31:0] LP_T3 = 32'(3 * CPE_INT);
    localparam logic [31:0] LP_T4 = 32'(4 * CPE_INT);
    localparam logic [31:0] LP_T5 = 32'(5 * CPE_INT);

    logic [15:0] r_period_cnt;
    logic [15:0] r_mech_count;
    logic [15:0] r_elec_count;

    logic        w_run;
    logic        w_step;
    logic        w_load_ok;
    logic [15:0] w_next_mech;
    logic [15:0] w_next_elec;
    logic [31:0] w_elec_x6;
    logic [2:0]  w_next_hall;

    // Step decision: free-running period counter compared to the requested period.
    always_comb begin
        w_run     = emulator_enable_in && (step_period_in != 16'd0);
        w_step    = w_run && (r_period_cnt >= (step_period_in - 16'd1));
        w_load_ok = position_load_in && (position_in < LP_CPR);
    end

    // Next mechanical/electrical count; a valid load takes priority over a step.
    always_comb begin
        w_next_mech = r_mech_count;
        w_next_elec = r_elec_count;
        if (w_load_ok) begin
            w_next_mech = position_in;
            w_next_elec = position_in % LP_CPE;
        end else if (w_step) begin
            if (rotate_direction_in) begin
                w_next_mech = (r_mech_count == LP_CPR - 16'd1) ? 16'd0 : r_mech_count + 16'd1;
                w_next_elec = (r_elec_count == LP_CPE - 16'd1) ? 16'd0 : r_elec_count + 16'd1;
            end else begin
                w_next_mech = (r_mech_count == 16'd0) ? LP_CPR - 16'd1 : r_mech_count - 16'd1;
                w_next_elec = (r_elec_count == 16'd0) ? LP_CPE - 16'd1 : r_elec_count - 16'd1;
            end
        end
    end

    // Hall sector lookup for the next electrical count (UVW, U in bit 2).
    always_comb begin
        w_elec_x6 = {16'd0, w_next_elec} * 32'd6;
        if (w_elec_x6 < LP_T1) begin
            w_next_hall = 3'b100;
        end else if (w_elec_x6 < LP_T2) begin
            w_next_hall = 3'b110;
        end else if (w_elec_x6 < LP_T3) begin
            w_next_hall = 3'b010;
        end else if (w_elec_x6 < LP_T4) begin
            w_next_hall = 3'b011;
        end else if (w_elec_x6 < LP_T5) begin
            w_next_hall = 3'b001;
        end else begin
            w_next_hall = 3'b101;
        end
    end

    // Period counter: cleared when idle, on a step, or on a load.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_period_cnt <= 16'd0;
        end else if (w_load_ok || !w_run || w_step) begin
            r_period_cnt <= 16'd0;
        end else begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end

    // Position state and all registered sensor outputs.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_mech_count   <= 16'd0;
            r_elec_count   <= 16'd0;
            encoder_a_out  <= 1'b0;
            encoder_b_out  <= 1'b0;
            encoder_z_out  <= 1'b1;
            hall_u_out     <= 1'b1;
            hall_v_out     <= 1'b0;
            hall_w_out     <= 1'b0;
            step_valid_out <= 1'b0;
        end else begin
            r_mech_count   <= w_next_mech;
            r_elec_count   <= w_next_elec;
            encoder_a_out  <= w_next_mech[0] ^ w_next_mech[1];
            encoder_b_out  <= w_next_mech[1];
            encoder_z_out  <= (w_next_mech == 16'd0);
            hall_u_out     <= w_next_hall[2];
            hall_v_out     <= w_next_hall[1];
            hall_w_out     <= w_next_hall[0];
            step_valid_out <= w_step && !w_load_ok;
        end
    end

    assign mech_count_out = r_mech_count;

endmodule

// File: tb/tb_motor_position_sensor_emulator_module.sv
// Directed self-checking bench for the motor position sensor emulator.
// Observed bundle: {A, B, Z, U, V, W, step_valid, mech_count[15:0]}.
module tb_motor_position_sensor_emulator_module;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        emulator_enable_in;
    logic        rotate_direction_in;
    logic [15:0] step_period_in;
    logic        position_load_in;
    logic [15:0] position_in;
    logic        encoder_a_out;
    logic        encoder_b_out;
    logic        encoder_z_out;
    logic        hall_u_out;
    logic        hall_v_out;
    logic        hall_w_out;
    logic [15:0] mech_count_out;
    logic        step_valid_out;

    int n_cmp = 0;
    int n_err = 0;

    motor_position_sensor_emulator_module dut (
        .sys_clk            (sys_clk),
        .reset_n            (reset_n),
        .emulator_enable_in (emulator_enable_in),
        .rotate_direction_in(rotate_direction_in),
        .step_period_in     (step_period_in),
        .position_load_in   (position_load_in),
        .position_in        (position_in),
        .encoder_a_out      (encoder_a_out),
        .encoder_b_out      (encoder_b_out),
        .encoder_z_out      (encoder_z_out),
        .hall_u_out         (hall_u_out),
        .hall_v_out         (hall_v_out),
        .hall_w_out         (hall_w_out),
        .mech_count_out     (mech_count_out),
        .step_valid_out     (step_valid_out)
    );

    always #5 sys_clk = ~sys_clk;

    logic [22:0] obs;
    assign obs = {encoder_a_out, encoder_b_out, encoder_z_out,
                  hall_u_out, hall_v_out, hall_w_out,
                  step_valid_out, mech_count_out};

    function automatic logic [22:0] pk(input logic [1:0] ab, input logic z,
                                       input logic [2:0] uvw, input logic sv,
                                       input logic [15:0] cnt);
        return {ab, z, uvw, sv, cnt};
    endfunction

    function automatic logic [2:0] exp_hall(input int e);
        if (e < 167) return 3'b100;
        else if (e < 334) return 3'b110;
        else if (e < 500) return 3'b010;
        else if (e < 667) return 3'b011;
        else if (e < 834) return 3'b001;
        else return 3'b101;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        reset_n = 1'b0;
        emulator_enable_in = 1'b0;
        rotate_direction_in = 1'b1;
        step_period_in = 16'd0;
        position_load_in = 1'b0;
        position_in = 16'd0;
        tick();
        tick();
        e = pk(2'b00, 1'b1, 3'b100, 1'b0, 16'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs, e);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_period4();
        logic [1:0] ab_tab [4];
        logic [22:0] e;
        ab_tab[0] = 2'b10;
        ab_tab[1] = 2'b11;
        ab_tab[2] = 2'b01;
        ab_tab[3] = 2'b00;
        emulator_enable_in = 1'b1;
        rotate_direction_in = 1'b1;
        step_period_in = 16'd4;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                n_cmp++;
                if (step_valid_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL p4_idle s%0d c%0d: got %b want 0", s, c, step_valid_out);
                end
            end
            tick();
            e = pk(ab_tab[s], 1'b0, 3'b100, 1'b1, 16'(s + 1));
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL p4_step %0d: got %h want %h", s, obs, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [22:0] e;
        step_period_in = 16'd1;
        position_load_in = 1'b1;
        position_in = 16'd3999;
        tick();
        e = pk(2'b01, 1'b0, 3'b101, 1'b0, 16'd3999);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL wrap_load: got %h want %h", obs, e);
        end
        position_load_in = 1'b0;
        tick();
        e = pk(2'b00, 1'b1, 3'b100, 1'b1, 16'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL wrap_fwd: got %h want %h", obs, e);
        end
        rotate_direction_in = 1'b0;
        tick();
        e = pk(2'b01, 1'b0, 3'b101, 1'b1, 16'd3999);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL wrap_rev: got %h want %h", obs, e);
        end
    endtask

    task automatic test_hall_sweep();
        logic [18:0] e;
        logic [18:0] o;
        rotate_direction_in = 1'b1;
        position_load_in = 1'b1;
        position_in = 16'd0;
        tick();
        position_load_in = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            e = {exp_hall(i % 1000), 16'(i)};
            o = {hall_u_out, hall_v_out, hall_w_out, mech_count_out};
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sweep %0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_load_rules();
        logic [22:0] e;
        emulator_enable_in = 1'b0;
        tick();
        emulator_enable_in = 1'b1;
        step_period_in = 16'd4;
        tick();
        tick();
        position_load_in = 1'b1;
        position_in = 16'd5000;
        tick();
        e = pk(2'b00, 1'b0, 3'b100, 1'b0, 16'd1000);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL bad_load: got %h want %h", obs, e);
        end
        position_load_in = 1'b0;
        tick();
        e = pk(2'b10, 1'b0, 3'b100, 1'b1, 16'd1001);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL bad_load_step: got %h want %h", obs, e);
        end
        tick();
        tick();
        tick();
        position_load_in = 1'b1;
        position_in = 16'd2000;
        tick();
        e = pk(2'b00, 1'b0, 3'b100, 1'b0, 16'd2000);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL load_vs_step: got %h want %h", obs, e);
        end
        position_load_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL post_load_idle %0d: got %h want %h", c, obs, e);
            end
        end
        tick();
        e = pk(2'b10, 1'b0, 3'b100, 1'b1, 16'd2001);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL post_load_step: got %h want %h", obs, e);
        end
    endtask

    task automatic test_freeze();
        logic [22:0] e;
        e = pk(2'b10, 1'b0, 3'b100, 1'b0, 16'd2001);
        step_period_in = 16'd0;
        for (int c = 0; c < 50; c++) begin
            tick();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL period0 %0d: got %h want %h", c, obs, e);
            end
        end
        step_period_in = 16'd4;
        emulator_enable_in = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL disabled %0d: got %h want %h", c, obs, e);
            end
        end
        emulator_enable_in = 1'b1;
        step_period_in = 16'd100;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL p100_idle %0d: got %h want %h", c, obs, e);
            end
        end
        step_period_in = 16'd2;
        tick();
        e = pk(2'b11, 1'b0, 3'b100, 1'b1, 16'd2002);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL period_shrink: got %h want %h", obs, e);
        end
    endtask

    task automatic test_direction();
        logic [22:0] e;
        rotate_direction_in = 1'b0;
        step_period_in = 16'd1;
        tick();
        e = pk(2'b10, 1'b0, 3'b100, 1'b1, 16'd2001);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rev1: got %h want %h", obs, e);
        end
        tick();
        e = pk(2'b00, 1'b0, 3'b100, 1'b1, 16'd2000);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rev2: got %h want %h", obs, e);
        end
        tick();
        e = pk(2'b01, 1'b0, 3'b101, 1'b1, 16'd1999);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rev3: got %h want %h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e;
        rotate_direction_in = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        position_load_in = 1'b1;
        position_in = 16'd123;
        tick();
        e = pk(2'b00, 1'b1, 3'b100, 1'b0, 16'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid: got %h want %h", obs, e);
        end
        reset_n = 1'b1;
        position_load_in = 1'b0;
        tick();
        e = pk(2'b10, 1'b0, 3'b100, 1'b1, 16'd1);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_resume: got %h want %h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_period4();
        test_wrap();
        test_hall_sweep();
        test_load_rules();
        test_freeze();
        test_direction();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_position_sensor_emulator_module.md
MOTOR_POSITION_SENSOR_EMULATOR_MODULE -- requirements
Module: motor_position_sensor_emulator_module

Interface
REQ-001 Parameter ENCODER_LINES, default 1000, encoder lines per mechanical revolution; counts per revolution CPR = 4*ENCODER_LINES.
REQ-002 Parameter POLE_PAIRS, default 4, motor pole pairs; CPR/POLE_PAIRS SHALL be an integer CPE (default 1000) and CPE SHALL be at least 6.
REQ-003 sys_clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 emulator_enable_in  in  1  1 = stepping permitted; 0 = freeze position.
REQ-006 rotate_direction_in  in  1  1 = forward (count up), 0 = reverse (count down).
REQ-007 step_period_in  in  16  sys_clk cycles per quadrature count; 0 = stopped.
REQ-008 position_load_in  in  1  one-cycle strobe loading position_in.
REQ-009 position_in  in  16  mechanical count to load, range 0..CPR-1.
REQ-010 encoder_a_out, encoder_b_out, encoder_z_out  out  1 each  emulated quadrature A/B and index.
REQ-011 hall_u_out, hall_v_out, hall_w_out  out  1 each  emulated hall signals.
REQ-012 mech_count_out  out  16  current mechanical count.
REQ-013 step_valid_out  out  1  one-cycle pulse when mech_count_out changes by a step.

Function
REQ-014 Period counter SHALL increment each cycle while enable=1 and step_period_in!=0, and issue a step when counter >= step_period_in-1, then clear to 0.
REQ-015 step_period_in=N, N>=1: exactly one step per N cycles; N=1 steps every cycle; decreasing N mid-count steps on next cycle.
REQ-016 enable=0 or step_period_in=0: counter cleared, no steps, all outputs hold.
REQ-017 Step: mech count +1 (forward) or -1 (reverse), direction sampled in the stepping cycle; wrap CPR-1 -> 0 forward and 0 -> CPR-1 reverse.
REQ-018 Electrical count SHALL track mech count modulo CPE, wrapping identically in both directions.
REQ-019 All outputs registered; outputs reflect a step one cycle after the step decision; step_valid_out asserted in that same cycle.
REQ-020 Quadrature state from count mod 4: 0 -> A=0 B=0, 1 -> A=1 B=0, 2 -> A=1 B=1, 3 -> A=0 B=1; forward A leads B by 90 deg; exactly one of A/B toggles per step.
REQ-021 encoder_z_out = 1 exactly while mech count = 0.
REQ-022 Hall sector = floor(6*elec_count/CPE); sectors 0..5 map UVW = 100,110,010,011,001,101; never 000 or 111.
REQ-023 Defaults: sector boundaries at elec_count 0,167,334,500,667,834.
REQ-024 position_load_in=1 with position_in<CPR: count loaded, elec count = position_in mod CPE, period counter cleared, all outputs updated next cycle, step_valid_out=0.
REQ-025 position_load_in with position_in>=CPR: ignored entirely (no load, stepping unaffected).
REQ-026 Load and step decision in same cycle: load wins, step discarded.
REQ-027 Direction change between steps: no glitch; next step reverses the quadrature sequence.

Reset
REQ-028 reset_n=0 at a clock edge: mech/elec count 0, period counter 0, A=0 B=0 Z=1, UVW=100, mech_count_out=0, step_valid_out=0.
REQ-029 Reset mid-operation overrides load and step in the same cycle; stepping resumes from count 0 after release.

Verification
REQ-030 Reset, enable=1, dir=1, period=4: step_valid every 4 cycles; A/B sequence 00,10,11,01,00; Z falls after first step.
REQ-031 Load 3999, dir=1, period=1: next step gives count 0, Z=1, UVW=100; dir=0 then gives 3999, UVW=101.
REQ-032 Forward sweep 0..999 at period=1: hall transitions at counts 167,334,500,667,834,1000 through 110,010,011,001,101,100; no 000/111.
REQ-033 Load 5000: count, outputs and period counter unchanged; load 2000 coincident with step: count 2000, step_valid_out=0.
REQ-034 Period=0 or enable=0 for 50 cycles: no output changes; period change 100->2 mid-count: step on next cycle.
REQ-035 Assert reset_n=0 during stepping and a coincident load: all outputs match REQ-028 values the following cycle.
